// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between the pipeline writeback (port 0)
// and a long-latency unit (port 1), with a starvation guard for port 1 and a one-entry output stage.
module rf_write_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_write_enabled,
  input  logic [4:0]            p0_address,
  input  logic [DATA_WIDTH-1:0] p0_data,
  input  logic [31:0]           p0_program_count,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic                  p1_write_enabled,
  input  logic [4:0]            p1_address,
  input  logic [DATA_WIDTH-1:0] p1_data,
  input  logic [31:0]           p1_program_count,
  output logic                  register_file_write_enabled,
  output logic [4:0]            register_file_write_address,
  output logic [DATA_WIDTH-1:0] register_file_write_data,
  output logic [31:0]           debug_program_count,
  output logic [3:0]            debug_register_file_write_enabled,
  output logic [4:0]            debug_register_file_write_address,
  output logic [DATA_WIDTH-1:0] debug_register_file_write_data,
  output logic                  p1_priority
);
  localparam logic [3:0] MAX = 4'(MAX_WAIT);
  typedef enum logic {P0_FIRST, P1_FIRST} state_t;
  state_t                state;
  logic [3:0]            wait_count;
  logic [3:0]            wait_next;
  logic                  p0_fire;
  logic                  p1_fire;
  logic                  p1_denied;
  logic                  out_valid;
  logic                  out_write_enabled;
  logic [4:0]            out_address;
  logic [DATA_WIDTH-1:0] out_data;
  logic [31:0]           out_program_count;
  always_comb begin
    p0_ready = state == P0_FIRST ? 1'b1 : !p1_valid;
    p1_ready = state == P1_FIRST ? 1'b1 : !p0_valid;
    p0_fire = p0_valid && p0_ready;
    p1_fire = p1_valid && p1_ready;
    p1_denied = p1_valid && !p1_ready;
    wait_next = (!p1_valid || p1_fire) ? 4'd0 :
                (p1_denied && wait_count != MAX) ? wait_count + 4'd1 : wait_count;
  end
  // P1_FIRST lasts until port 1 either retires its request or withdraws it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= P0_FIRST;
      wait_count <= 4'd0;
      out_valid <= 1'b0;
      out_write_enabled <= 1'b0;
      out_address <= 5'd0;
      out_data <= '0;
      out_program_count <= 32'd0;
    end else begin
      state <= state == P0_FIRST ? ((p1_denied && wait_next == MAX) ? P1_FIRST : P0_FIRST) :
               ((p1_fire || !p1_valid) ? P0_FIRST : P1_FIRST);
      wait_count <= wait_next;
      out_valid <= p0_fire || p1_fire;
      if (p1_fire) begin
        out_write_enabled <= p1_write_enabled;
        out_address <= p1_address;
        out_data <= p1_data;
        out_program_count <= p1_program_count;
      end else if (p0_fire) begin
        out_write_enabled <= p0_write_enabled;
        out_address <= p0_address;
        out_data <= p0_data;
        out_program_count <= p0_program_count;
      end
    end
  end
  assign register_file_write_enabled = out_valid && out_write_enabled && out_address != 5'd0;
  assign register_file_write_address = out_address;
  assign register_file_write_data = out_data;
  assign debug_program_count = out_program_count;
  assign debug_register_file_write_enabled = {4{register_file_write_enabled}};
  assign debug_register_file_write_address = out_address;
  assign debug_register_file_write_data = out_data;
  assign p1_priority = state == P1_FIRST;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed test-plan scenarios plus randomized traffic checked against a
// priority/denial-count reference model of the arbiter.
module tb_rf_write_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int DW = 32;
  logic clock = 0;
  logic reset = 1;
  logic p0_valid = 0, p0_write_enabled = 0, p1_valid = 0, p1_write_enabled = 0;
  logic [4:0] p0_address = 0, p1_address = 0;
  logic [DW-1:0] p0_data = 0, p1_data = 0;
  logic [31:0] p0_program_count = 0, p1_program_count = 0;
  logic p0_ready, p1_ready, register_file_write_enabled, p1_priority;
  logic [4:0] register_file_write_address, debug_register_file_write_address;
  logic [DW-1:0] register_file_write_data, debug_register_file_write_data;
  logic [31:0] debug_program_count;
  logic [3:0] debug_register_file_write_enabled;

  rf_write_arbiter #(.MAX_WAIT(MAX_WAIT), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_write_enabled(p0_write_enabled),
    .p0_address(p0_address), .p0_data(p0_data), .p0_program_count(p0_program_count),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_write_enabled(p1_write_enabled),
    .p1_address(p1_address), .p1_data(p1_data), .p1_program_count(p1_program_count),
    .register_file_write_enabled(register_file_write_enabled),
    .register_file_write_address(register_file_write_address),
    .register_file_write_data(register_file_write_data),
    .debug_program_count(debug_program_count),
    .debug_register_file_write_enabled(debug_register_file_write_enabled),
    .debug_register_file_write_address(debug_register_file_write_address),
    .debug_register_file_write_data(debug_register_file_write_data),
    .p1_priority(p1_priority)
  );

  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  bit m_fav1, m_valid, m_we, t0, t1;
  int m_den;
  logic [4:0] m_addr;
  logic [DW-1:0] m_data;
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_fav1 = 0; m_den = 0; m_valid = 0; m_we = 0; m_addr = 0; m_data = 0; m_pc = 0;
    t0 = 0; t1 = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_we"}, register_file_write_enabled, 0);
    check({tag, "_dbg_we"}, debug_register_file_write_enabled, 0);
    check({tag, "_addr"}, register_file_write_address, 0);
    check({tag, "_data"}, register_file_write_data, 0);
    check({tag, "_dbg_pc"}, debug_program_count, 0);
    check({tag, "_dbg_addr"}, debug_register_file_write_address, 0);
    check({tag, "_dbg_data"}, debug_register_file_write_data, 0);
    check({tag, "_prio"}, p1_priority, 0);
  endtask

  // Asserts reset (asynchronously), checks cleared outputs and ready equations, releases after posedge+1
  task automatic do_reset(input string tag);
    reset = 1;
    #1;
    check_zero_outputs(tag);
    check({tag, "_p0_ready"}, p0_ready, 1);
    check({tag, "_p1_ready"}, p1_ready, !p0_valid);
    p0_valid = 0;
    p1_valid = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    model_clear();
  endtask

  task automatic drive(input int n, input bit we, input logic [4:0] a, input logic [DW-1:0] d,
                       input logic [31:0] pc);
    if (n == 0) begin
      p0_valid = 1; p0_write_enabled = we; p0_address = a; p0_data = d; p0_program_count = pc;
    end else begin
      p1_valid = 1; p1_write_enabled = we; p1_address = a; p1_data = d; p1_program_count = pc;
    end
  endtask

  // One cycle: called at posedge+1 with inputs set; returns at the next posedge+1
  task automatic tick();
    bit v[2];
    bit r[2];
    int pref;
    #1;
    v[0] = p0_valid;
    v[1] = p1_valid;
    pref = m_fav1 ? 1 : 0;
    for (int n = 0; n < 2; n++) r[n] = (pref == n) || !v[1-n];
    check("p0_ready", p0_ready, r[0]);
    check("p1_ready", p1_ready, r[1]);
    t0 = v[0] && r[0];
    t1 = v[1] && r[1];
    m_den = (v[1] && !r[1]) ? m_den + 1 : 0;
    m_fav1 = m_den == MAX_WAIT;
    m_valid = t0 || t1;
    if (t1) begin
      m_we = p1_write_enabled; m_addr = p1_address; m_data = p1_data; m_pc = p1_program_count;
    end else if (t0) begin
      m_we = p0_write_enabled; m_addr = p0_address; m_data = p0_data; m_pc = p0_program_count;
    end
    @(posedge clock);
    #1;
    check("rf_we", register_file_write_enabled, m_valid && m_we && m_addr != 0);
    check("dbg_we", debug_register_file_write_enabled, {4{m_valid && m_we && m_addr != 0}});
    check("rf_addr", register_file_write_address, m_addr);
    check("rf_data", register_file_write_data, m_data);
    check("dbg_addr", debug_register_file_write_address, m_addr);
    check("dbg_data", debug_register_file_write_data, m_data);
    check("dbg_pc", debug_program_count, m_pc);
    check("p1_priority", p1_priority, m_fav1);
  endtask

  function automatic logic [4:0] rand_addr();
    return $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction

  int strobes;

  initial begin
    model_clear();
    @(posedge clock);
    do_reset("init");
    // single port-0 write
    drive(0, 1, 5'd5, 32'h1234, 32'hBFC00000);
    tick();
    p0_valid = 0;
    check("tp1_we", register_file_write_enabled, 1);
    check("tp1_dbg_we", debug_register_file_write_enabled, 4'hF);
    check("tp1_addr", register_file_write_address, 5);
    check("tp1_data", register_file_write_data, 32'h1234);
    check("tp1_pc", debug_program_count, 32'hBFC00000);
    // both ports busy: port 1 wins on the fifth cycle
    drive(1, 1, 5'd9, 32'hAAAA0001, 32'h1000);
    drive(0, 1, 5'd3, 32'h0, 32'h2000);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 3) check("tp2_prio_on", p1_priority, 1);
      if (c == 4) begin
        check("tp2_prio_off", p1_priority, 0);
        check("tp2_p1_addr", register_file_write_address, 9);
      end
      if (t1) p1_valid = 0;
      if (t0) drive(0, 1, 5'd3, DW'(c), 32'h2004 + 32'(c));
    end
    p0_valid = 0;
    tick();
    // port 1 alone writing $0: retires without a strobe
    drive(1, 1, 5'd0, 32'hDEAD, 32'h3000);
    tick();
    p1_valid = 0;
    check("tp3_we", register_file_write_enabled, 0);
    check("tp3_pc", debug_program_count, 32'h3000);
    // withdrawal after 2 denials restarts the count
    drive(0, 1, 5'd4, 32'h44, 32'h4000);
    drive(1, 1, 5'd6, 32'h66, 32'h4100);
    repeat (2) tick();
    p1_valid = 0;
    tick();
    p1_valid = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 2) check("tp4_prio_wait", p1_priority, 0);
      if (c == 3) check("tp4_prio_on", p1_priority, 1);
    end
    tick();
    p0_valid = 0;
    p1_valid = 0;
    tick();
    // reset in the middle of a cycle with a retiring entry and 2 port-1 denials
    drive(0, 1, 5'd7, 32'h77, 32'h5000);
    drive(1, 1, 5'd8, 32'h88, 32'h5100);
    repeat (2) tick();
    check("tp5_pre_we", register_file_write_enabled, 1);
    #2;
    do_reset("tp5");
    drive(0, 1, 5'd7, 32'h77, 32'h5000);
    drive(1, 1, 5'd8, 32'h88, 32'h5100);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 2) check("tp5_prio_wait", p1_priority, 0);
      if (c == 3) check("tp5_prio_on", p1_priority, 1);
    end
    p0_valid = 0;
    tick();
    p1_valid = 0;
    // back-to-back port-0 writes, alternating addresses
    strobes = 0;
    for (int c = 0; c < 8; c++) begin
      drive(0, 1, (c % 2 == 0) ? 5'd1 : 5'd2, DW'($urandom), 32'h6000 + 32'(4 * c));
      tick();
      if (register_file_write_enabled) strobes++;
    end
    p0_valid = 0;
    check("tp6_strobes", strobes, 8);
    tick();
    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      if (!p0_valid && $urandom_range(0, 2) != 0)
        drive(0, $urandom_range(0, 3) != 0, rand_addr(), DW'($urandom), $urandom);
      if (!p1_valid && $urandom_range(0, 3) == 0)
        drive(1, $urandom_range(0, 3) != 0, rand_addr(), DW'($urandom), $urandom);
      else if (p1_valid && $urandom_range(0, 15) == 0)
        p1_valid = 0;
      tick();
      if (t0) p0_valid = 0;
      if (t1) p1_valid = 0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two writeback sources:
  - port 0: the main pipeline writeback, normal priority.
  - port 1: a long-latency unit, e.g. mul/div or an uncached load return.
- Accepts at most one request per cycle and registers it into a one-entry output stage that drives the register file and the trace debug interface.
- Sits between the writeback stage / long-latency unit and the register file.
- A starvation counter guarantees port 1 forward progress.

Parameters:
- MAX_WAIT, 4, cycles port 1 may be denied while valid before it takes priority (legal range 1..15).
- DATA_WIDTH, 32, register data width.

Ports:
- clock  in  1  system clock
- reset  in  1  reset. One clock; reset is asynchronous and active-high.
- p0_valid  in  1  port 0 request valid
- p0_ready  out  1  port 0 request accepted this cycle
- p0_write_enabled  in  1  port 0 writes a register
- p0_address  in  5  port 0 destination register
- p0_data  in  DATA_WIDTH  port 0 write data
- p0_program_count  in  32  port 0 instruction PC
- p1_valid, p1_ready, p1_write_enabled, p1_address, p1_data, p1_program_count: same as port 0, for port 1
- register_file_write_enabled  out  1  register file write strobe
- register_file_write_address  out  5  register file write address
- register_file_write_data  out  DATA_WIDTH  register file write data
- debug_program_count  out  32  PC of the retiring entry
- debug_register_file_write_enabled  out  4  strobe replicated to 4 bits
- debug_register_file_write_address  out  5  write address
- debug_register_file_write_data  out  DATA_WIDTH  write data
- p1_priority  out  1  high while FSM is in P1_FIRST

Behaviour:
- Handshake:
  - Transfer occurs when valid && ready.
  - Requesters hold valid and payload stable until ready.
  - pN_ready never depends on pN_valid itself.
- FSM states: P0_FIRST (reset state), P1_FIRST.
  - In P0_FIRST: p0_ready = 1; p1_ready = !p0_valid.
  - In P1_FIRST: p1_ready = 1; p0_ready = !p1_valid.
- Wait counter (4 bits):
  - Reset 0.
  - Increments, saturating at MAX_WAIT, each cycle p1_valid && !p1_ready.
  - Clears on a p1 transfer or when p1_valid is low.
- Transitions:
  - P0_FIRST -> P1_FIRST when the counter reaches MAX_WAIT, i.e. the MAX_WAIT-th consecutive denial. The next cycle favours port 1.
  - P1_FIRST -> P0_FIRST on a p1 transfer.
  - P1_FIRST -> P0_FIRST when p1_valid is low (the request was withdrawn by a flush).
- Output stage:
  - out_valid <= (p0 transfer || p1 transfer).
  - The payload register loads from the transferring port.
  - Latency: exactly 1 cycle from transfer to register_file_write_enabled.
  - Output stage never stalls; throughput is 1 write per cycle.
- register_file_write_enabled = out_valid && out_write_enabled && (out_address != 0).
  - Writes to $0 are still accepted and retired, but the strobe stays 0.
- Debug outputs:
  - Mirror the output stage.
  - debug_register_file_write_enabled = {4{register_file_write_enabled}}.
  - debug_program_count updates on every retire, including non-writing retires.
- Ordering:
  - Same-address ordering between ports is the issuer's responsibility.
  - Simultaneous same-address requests resolve purely by FSM priority.
- Reset:
  - Asynchronous assertion, including mid-transfer, immediately clears out_valid, the FSM (P0_FIRST), the counter and all register_file/debug outputs to 0.
  - A request in flight at reset is dropped; the requester must re-present it.
  - p0_ready / p1_ready during reset follow the P0_FIRST equations.

Test Plan:
- Port 0 only, address 5, data 0x1234, PC 0xBFC00000 -> p0_ready = 1. Next cycle register_file_write_enabled = 1, address 5, data 0x1234, debug enable 4'hF, debug PC 0xBFC00000.
- Both ports valid continuously, MAX_WAIT = 4 -> port 0 granted cycles 0-3. Cycle 4: p1_priority = 1, p1 granted, p0_ready = 0. Cycle 5: back to P0_FIRST.
- Port 1 alone, address 0, write_enabled = 1 -> accepted. Next cycle debug PC updates, register_file_write_enabled = 0.
- p1 withdrawn (p1_valid -> 0) after 2 denials -> counter returns to 0, no FSM change. A later p1 request needs 4 fresh denials.
- reset asserted mid-cycle while out_valid = 1 -> outputs go to 0 immediately (asynchronously). After deassert: P0_FIRST, counter 0.
- Back-to-back p0 transfers for 8 cycles with alternating addresses 1/2 -> 8 consecutive write strobes, each 1 cycle late, no bubbles.
